read_sram: RTL and testbench

//  Read-side counterpart of the SRAM block writer. Accepts one block address per request and

---
 rtl/read_sram_pkg.sv | 11 +
 rtl/read_sram_tagpipe.sv | 27 ++
 rtl/read_sram.sv | 88 ++++++++
 tb/tb_read_sram.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/read_sram_pkg.sv
// read_sram_pkg: shared widths, FSM state and read-tag types for the SRAM block reader.
package read_sram_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BLK_ADDR_WIDTH = 4;
  typedef enum logic {IDLE, READ} rd_state_e;
  typedef struct packed {
    logic                      vld;
    logic                      last;
    logic [BLK_ADDR_WIDTH-1:0] blk_addr;
  } rd_tag_t;
endpackage

// File: rtl/read_sram_tagpipe.sv
// read_sram_tagpipe: SRAM_RD_LAT-deep shift of read tags, aligned with returning SRAM data.
module read_sram_tagpipe
  import read_sram_pkg::*;
#(
  parameter int SRAM_RD_LAT = 1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag,
  output logic    o_any_vld
);
  rd_tag_t sr_q [SRAM_RD_LAT];
  rd_tag_t sr_d [SRAM_RD_LAT];
  always_comb begin
    sr_d = sr_q;
    sr_d[0] = i_tag;
    for (int i = 1; i < SRAM_RD_LAT; i++) sr_d[i] = sr_q[i-1];
    o_any_vld = 1'b0;
    for (int i = 0; i < SRAM_RD_LAT; i++) o_any_vld = o_any_vld | sr_q[i].vld;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  end
  assign o_tag = sr_q[SRAM_RD_LAT-1];
endmodule

// File: rtl/read_sram.sv
// read_sram: reads one SRAM block per request into the output FIFO, throttled by afull.
// Optional READ_SRAM_FREE_EN: report each fully-read block on o_free_vld/o_free_addr.
module read_sram
  import read_sram_pkg::*;
#(
  parameter int WORD_SEL_WIDTH = 3,
  parameter int SRAM_RD_LAT    = 1
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [BLK_ADDR_WIDTH-1:0]                i_blk_addr,
  input  logic                                     i_blk_addr_vld,
  output logic                                     o_blk_addr_rdy,
  output logic [BLK_ADDR_WIDTH+WORD_SEL_WIDTH-1:0] o_sram_addr,
  output logic                                     o_sram_ren,
  input  logic [DATA_WIDTH-1:0]                    i_sram_data,
  output logic [DATA_WIDTH-1:0]                    o_fifo_data,
  output logic                                     o_fifo_wen,
  input  logic                                     i_fifo_afull,
  output logic                                     o_blk_done,
  output logic                                     o_busy,
  output logic [BLK_ADDR_WIDTH-1:0]                o_free_addr,
  output logic                                     o_free_vld
);
  rd_state_e                 state_q, state_d;
  logic [BLK_ADDR_WIDTH-1:0] blk_q, blk_d;
  logic [WORD_SEL_WIDTH-1:0] idx_q, idx_d;
  logic                      last_word, any_vld;
  rd_tag_t                   tag_in, tag_out;
  assign last_word = &idx_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    if (state_q == IDLE && i_blk_addr_vld) begin
      state_d = READ;
      blk_d   = i_blk_addr;
      idx_d   = '0;
    end else if (state_q == READ && !i_fifo_afull) begin
      idx_d   = idx_q + WORD_SEL_WIDTH'(1);
      state_d = last_word ? IDLE : READ;
    end
  end
  // Everything is forced low while reset is held so in-flight reads never reach the FIFO.
  always_comb begin
    o_blk_addr_rdy = !i_rst && state_q == IDLE;
    o_sram_ren     = !i_rst && state_q == READ && !i_fifo_afull;
    o_sram_addr    = o_sram_ren ? {blk_q, idx_q} : '0;
    tag_in.vld     = o_sram_ren;
    tag_in.last    = o_sram_ren && last_word;
`ifdef READ_SRAM_FREE_EN
    tag_in.blk_addr = blk_q;
`else
    tag_in.blk_addr = '0;
`endif
    o_fifo_wen  = !i_rst && tag_out.vld;
    o_fifo_data = o_fifo_wen ? i_sram_data : '0;
    o_blk_done  = o_fifo_wen && tag_out.last;
    o_busy      = !i_rst && (state_q != IDLE || any_vld);
  end
  read_sram_tagpipe #(.SRAM_RD_LAT(SRAM_RD_LAT)) u_tagpipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_tag    (tag_in),
    .o_tag    (tag_out),
    .o_any_vld(any_vld)
  );
`ifdef READ_SRAM_FREE_EN
  assign o_free_vld  = o_blk_done;
  assign o_free_addr = o_blk_done ? tag_out.blk_addr : '0;
`else
  logic unused_blk;
  assign unused_blk  = ^tag_out.blk_addr;
  assign o_free_vld  = 1'b0;
  assign o_free_addr = '0;
`endif
endmodule

// File: tb/tb_read_sram.sv
// tb_read_sram: table-driven checks of read_sram at SRAM_RD_LAT=1 with a LAT=2 shadow instance.
module tb_read_sram;
  import read_sram_pkg::*;
  localparam int AW = BLK_ADDR_WIDTH + 3;
  typedef struct {
    logic [BLK_ADDR_WIDTH-1:0] blk;
    int                        afull_after;
    int                        afull_len;
    logic [31:0]               first_word;
    int                        span;
    bit                        b2b;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, afull = 1'b0;
  logic [BLK_ADDR_WIDTH-1:0] blk_addr = '0;
  logic rdy1, ren1, wen1, done1, busy1, fv1, rdy2, ren2, wen2, done2, busy2, fv2;
  logic [AW-1:0] addr1, addr2;
  logic [DATA_WIDTH-1:0] sd1, sd2, p2, fd1, fd2;
  logic [BLK_ADDR_WIDTH-1:0] fa1, fa2;
  logic [DATA_WIDTH-1:0] mem [2**AW];
  int cyc = 0, checks = 0, failures = 0;
  int ren_cnt, first_ren, last_ren, acc_cyc, prev_last;
  int done_cnt = 0, free_cnt = 0, wen_cnt = 0, wen2_cnt = 0;
  bit acc, logging = 1'b0;
  logic [31:0] exp_q[$], log1_d[$], log2_d[$];
  int log1_c[$], log2_c[$];
  vec_t vecs[5];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    sd1 <= mem[addr1];
    p2  <= mem[addr2];
    sd2 <= p2;
  end
  read_sram #(.SRAM_RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_blk_addr(blk_addr), .i_blk_addr_vld(vld), .o_blk_addr_rdy(rdy1),
    .o_sram_addr(addr1), .o_sram_ren(ren1), .i_sram_data(sd1), .o_fifo_data(fd1), .o_fifo_wen(wen1),
    .i_fifo_afull(afull), .o_blk_done(done1), .o_busy(busy1), .o_free_addr(fa1), .o_free_vld(fv1));
  read_sram #(.SRAM_RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_blk_addr(blk_addr), .i_blk_addr_vld(vld), .o_blk_addr_rdy(rdy2),
    .o_sram_addr(addr2), .o_sram_ren(ren2), .i_sram_data(sd2), .o_fifo_data(fd2), .o_fifo_wen(wen2),
    .i_fifo_afull(afull), .o_blk_done(done2), .o_busy(busy2), .o_free_addr(fa2), .o_free_vld(fv2));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic sample();
    logic [31:0] e;
    acc = vld && rdy1;
    if (acc) acc_cyc = cyc;
    if (ren1) begin
      if (ren_cnt == 0) first_ren = cyc;
      last_ren = cyc;
      ren_cnt++;
    end
    if (afull) chk("ren_in_afull", ren1, 0);
    if (done1 && !wen1) chk("done_without_wen", 1, 0);
    if (fv1) free_cnt++;
    if (wen2) wen2_cnt++;
    if (wen2 && logging) begin log2_d.push_back(fd2); log2_c.push_back(cyc); end
    if (wen1) begin
      wen_cnt++;
      if (logging) begin log1_d.push_back(fd1); log1_c.push_back(cyc); end
      if (exp_q.size() == 0) chk("wen_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("fifo_data", fd1, e);
        chk("blk_done", done1, e[2:0] == 3'd0);
        if (done1) begin
          done_cnt++;
`ifdef READ_SRAM_FREE_EN
          chk("free_vld", fv1, 1);
          chk("free_addr", fa1, (e - 1) >> 3);
`else
          chk("free_vld_tied", fv1, 0);
          chk("free_addr_tied", fa1, 0);
`endif
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [BLK_ADDR_WIDTH-1:0] b);
    vld = 1'b1;
    blk_addr = b;
    for (int i = 0; i < 50; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2**AW; k++) mem[k] = (k < 32) ? DATA_WIDTH'(k + 1) : '0;
    vecs[0] = '{blk: 0, afull_after: 0, afull_len: 0, first_word: 1,  span: 8,  b2b: 0};
    vecs[1] = '{blk: 1, afull_after: 0, afull_len: 0, first_word: 9,  span: 8,  b2b: 1};
    vecs[2] = '{blk: 2, afull_after: 0, afull_len: 0, first_word: 17, span: 8,  b2b: 1};
    vecs[3] = '{blk: 3, afull_after: 0, afull_len: 0, first_word: 25, span: 8,  b2b: 1};
    vecs[4] = '{blk: 0, afull_after: 3, afull_len: 4, first_word: 1,  span: 12, b2b: 1};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rdy1, ren1, wen1, done1, busy1, fv1, addr1, fd1, fa1}, 0);
    rst = 1'b0;
    #1;
    chk("idle_rdy", rdy1, 1);
    chk("idle_busy", busy1, 0);
    logging = 1'b1;
    prev_last = 0;
    foreach (vecs[v]) begin
      int stall = 0;
      for (int k = 0; k < 8; k++) exp_q.push_back(vecs[v].first_word + 32'(k));
      ren_cnt = 0;
      req(vecs[v].blk);
      if (vecs[v].b2b) chk("b2b_accept", acc_cyc, prev_last + 1);
      for (int c = 0; c < 40 && ren_cnt < 8; c++) begin
        afull = vecs[v].afull_len > 0 && ren_cnt == vecs[v].afull_after && stall < vecs[v].afull_len;
        if (afull) stall++;
        if (c == 0) chk("busy_reading", busy1, 1);
        step();
      end
      afull = 1'b0;
      chk("ren_count", ren_cnt, 8);
      chk("first_ren", first_ren, acc_cyc + 1);
      chk("last_ren", last_ren, acc_cyc + vecs[v].span);
      prev_last = last_ren;
    end
    repeat (4) step();
    logging = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, 5);
    chk("busy_after_drain", busy1, 0);
    chk("lat2_count", log2_d.size(), log1_d.size());
    for (int i = 0; i < log1_d.size() && i < log2_d.size(); i++) begin
      chk("lat2_data", log2_d[i], log1_d[i]);
      chk("lat2_shift", log2_c[i], log1_c[i] + 1);
    end
    // reset while the fifth word of block 2 is being issued
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(17 + k));
    ren_cnt = 0;
    req(2);
    for (int c = 0; c < 20 && ren_cnt < 4; c++) step();
    chk("pre_reset_rens", ren_cnt, 4);
    rst = 1'b1;
    exp_q.delete();
    wen_cnt = 0;
    wen2_cnt = 0;
    step();
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", rdy1, 1);
    repeat (6) step();
    chk("no_wen_after_reset", wen_cnt, 0);
    chk("no_wen2_after_reset", wen2_cnt, 0);
    chk("done_after_reset", done_cnt, 5);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(17 + k));
    req(2);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) step();
    chk("reread_empty", exp_q.size(), 0);
    chk("reread_writes", wen_cnt, 8);
    chk("final_done_count", done_cnt, 6);
`ifdef READ_SRAM_FREE_EN
    chk("free_count", free_cnt, 6);
`else
    chk("free_count", free_cnt, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
